t07_flag_placer: RTL and testbench

Player-input stage directly upstream of the flag pixel generator. Synchronizes and debounces five raw push-buttons, moves a cursor over the 8x8 board, and places or removes a single flag at the cursor. It drives the flag block coordinates (flag_x, flag_y) and a flag_valid qualifier consumed by the pixel/colour path. The downstream mixer ANDs flag_valid with the generator's flag pixel.

---
 rtl/t07_flag_placer_if.sv | 29 ++
 rtl/t07_flag_placer.sv | 157 +++++++++++++++
 tb/tb_t07_flag_placer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/t07_flag_placer_if.sv
// Player-input bus between the raw button/control sources and the flag placer.
// The placer side uses the slave modport; whoever drives the buttons uses master.
interface t07_flag_placer_if;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic       btn_place;
    logic       game_active;
    logic       new_game;
    logic [2:0] cursor_x;
    logic [2:0] cursor_y;
    logic [2:0] flag_x;
    logic [2:0] flag_y;
    logic       flag_valid;
    logic       flag_event;

    modport master (
        output btn_up, btn_down, btn_left, btn_right, btn_place,
        output game_active, new_game,
        input  cursor_x, cursor_y, flag_x, flag_y, flag_valid, flag_event
    );

    modport slave (
        input  btn_up, btn_down, btn_left, btn_right, btn_place,
        input  game_active, new_game,
        output cursor_x, cursor_y, flag_x, flag_y, flag_valid, flag_event
    );
endinterface

// File: rtl/t07_flag_placer.sv
// Button synchronizer/debouncer lanes, cursor movement and single-flag placement
// feeding the flag pixel generator.

module t07_flag_placer_db #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DB_WIDTH        = 5
) (
    input  logic clk,
    input  logic nrst,
    input  logic raw,
    output logic press
);
    localparam logic [DB_WIDTH-1:0] CNT_LAST = DB_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [1:0]          sync;
    logic                level;
    logic                level_q;
    logic [DB_WIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync    <= '0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            sync    <= {sync[0], raw};
            level_q <= level;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // counter would reach DEBOUNCE_CYCLES: accept the new level
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press = level & ~level_q;
endmodule

module t07_flag_placer #(
    parameter int GRID_MAX        = 7,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DB_WIDTH        = 5
) (
    input  logic                  clk,
    input  logic                  nrst,
    t07_flag_placer_if.slave      bus
);
    localparam int NUM_BTN = 5;
    localparam int B_UP    = 0;
    localparam int B_DOWN  = 1;
    localparam int B_LEFT  = 2;
    localparam int B_RIGHT = 3;
    localparam int B_PLACE = 4;
    localparam logic [2:0] GMAX = 3'(GRID_MAX);

    typedef enum logic {LOCK = 1'b0, PLAY = 1'b1} state_t;

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] press;

    state_t     state, state_nxt;
    logic [2:0] cx, cy, fx, fy;
    logic [2:0] cx_nxt, cy_nxt, fx_nxt, fy_nxt;
    logic       fv, fv_nxt;
    logic       ev, ev_nxt;

    assign raw[B_UP]    = bus.btn_up;
    assign raw[B_DOWN]  = bus.btn_down;
    assign raw[B_LEFT]  = bus.btn_left;
    assign raw[B_RIGHT] = bus.btn_right;
    assign raw[B_PLACE] = bus.btn_place;

    // Lanes keep running in LOCK so a press seen while locked is consumed there.
    genvar g;
    generate
        for (g = 0; g < NUM_BTN; g++) begin : g_btn
            t07_flag_placer_db #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .DB_WIDTH        (DB_WIDTH)
            ) u_db (
                .clk   (clk),
                .nrst  (nrst),
                .raw   (raw[g]),
                .press (press[g])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= LOCK;
            cx    <= '0;
            cy    <= '0;
            fx    <= '0;
            fy    <= '0;
            fv    <= 1'b0;
            ev    <= 1'b0;
        end else begin
            state <= state_nxt;
            cx    <= cx_nxt;
            cy    <= cy_nxt;
            fx    <= fx_nxt;
            fy    <= fy_nxt;
            fv    <= fv_nxt;
            ev    <= ev_nxt;
        end
    end

    always_comb begin
        state_nxt = bus.game_active ? PLAY : LOCK;
        cx_nxt    = cx;
        cy_nxt    = cy;
        fx_nxt    = fx;
        fy_nxt    = fy;
        fv_nxt    = fv;
        ev_nxt    = 1'b0;
        if (bus.new_game) begin
            cx_nxt = '0;
            cy_nxt = '0;
            fx_nxt = '0;
            fy_nxt = '0;
            fv_nxt = 1'b0;
        end else if (state == PLAY) begin
            // One action per cycle; lower-priority strobes are dropped.
            if (press[B_PLACE]) begin
                ev_nxt = 1'b1;
                if (fv && fx == cx && fy == cy) begin
                    fv_nxt = 1'b0;
                end else begin
                    fx_nxt = cx;
                    fy_nxt = cy;
                    fv_nxt = 1'b1;
                end
            end else if (press[B_UP]) begin
                cy_nxt = (cy == 3'd0) ? GMAX : cy - 3'd1;
            end else if (press[B_DOWN]) begin
                cy_nxt = (cy == GMAX) ? 3'd0 : cy + 3'd1;
            end else if (press[B_LEFT]) begin
                cx_nxt = (cx == 3'd0) ? GMAX : cx - 3'd1;
            end else if (press[B_RIGHT]) begin
                cx_nxt = (cx == GMAX) ? 3'd0 : cx + 3'd1;
            end
        end
    end

    assign bus.cursor_x   = cx;
    assign bus.cursor_y   = cy;
    assign bus.flag_x     = fx;
    assign bus.flag_y     = fy;
    assign bus.flag_valid = fv;
    assign bus.flag_event = ev;
endmodule

// File: tb/tb_t07_flag_placer.sv
// Directed bench for t07_flag_placer: a reference model queues the expected
// board state per press and it is compared once the DUT reacts.
module tb_t07_flag_placer;
    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    t07_flag_placer_if bus ();

    t07_flag_placer #(
        .GRID_MAX        (7),
        .DEBOUNCE_CYCLES (16),
        .DB_WIDTH        (5)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    typedef struct packed {
        logic [2:0] cx;
        logic [2:0] cy;
        logic [2:0] fx;
        logic [2:0] fy;
        logic       fv;
        logic       ev;
    } st_t;

    localparam logic [4:0] UP = 5'b00001, DN = 5'b00010, LT = 5'b00100,
                           RT = 5'b01000, PL = 5'b10000;

    st_t mdl;
    st_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    function automatic st_t obs();
        st_t s;
        s.cx = bus.cursor_x;  s.cy = bus.cursor_y;
        s.fx = bus.flag_x;    s.fy = bus.flag_y;
        s.fv = bus.flag_valid; s.ev = bus.flag_event;
        return s;
    endfunction

    function automatic st_t apply(st_t s, logic [4:0] m);
        st_t r = s;
        r.ev = 1'b0;
        if (m[4]) begin
            r.ev = 1'b1;
            if (s.fv && s.fx == s.cx && s.fy == s.cy) r.fv = 1'b0;
            else begin r.fx = s.cx; r.fy = s.cy; r.fv = 1'b1; end
        end else if (m[0]) r.cy = (s.cy == 3'd0) ? 3'd7 : s.cy - 3'd1;
        else if (m[1])     r.cy = (s.cy == 3'd7) ? 3'd0 : s.cy + 3'd1;
        else if (m[2])     r.cx = (s.cx == 3'd0) ? 3'd7 : s.cx - 3'd1;
        else if (m[3])     r.cx = (s.cx == 3'd7) ? 3'd0 : s.cx + 3'd1;
        return r;
    endfunction

    task automatic chk(input string tag, input st_t got, input st_t want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, want);
        end
    endtask

    task automatic set_btn(input logic [4:0] m);
        bus.btn_up = m[0]; bus.btn_down = m[1]; bus.btn_left = m[2];
        bus.btn_right = m[3]; bus.btn_place = m[4];
    endtask

    // Wait (bounded) for the queued action to show up, compare, then release.
    task automatic await_act(input string tag);
        st_t prev = obs();
        st_t want = exp_q.pop_front();
        bit  seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (obs() !== prev) seen = 1'b1;
        end
        if (!seen) begin
            total++; bad++;
            $error("FAIL %s_timeout: observed=%h expected=%h", tag, obs(), want);
        end else chk(tag, obs(), want);
        @(negedge clk);
        mdl.ev = 1'b0;
        chk({tag, "_ev"}, obs(), mdl);
        set_btn(5'b0);
        repeat (25) @(negedge clk);
    endtask

    task automatic press(input string tag, input logic [4:0] m);
        mdl = apply(mdl, m);
        exp_q.push_back(mdl);
        set_btn(m);
        await_act(tag);
    endtask

    initial begin
        nrst = 1'b0;
        set_btn(5'b0);
        bus.game_active = 1'b0;
        bus.new_game    = 1'b0;
        mdl = '0;
        repeat (2) @(negedge clk);
        chk("reset", obs(), mdl);
        nrst = 1'b1;
        bus.game_active = 1'b1;
        repeat (3) @(negedge clk);

        // latency: action lands on the 19th edge after the button rises
        set_btn(RT);
        repeat (18) @(negedge clk);
        chk("lat_e18", obs(), mdl);
        @(negedge clk);
        mdl = apply(mdl, RT);
        chk("lat_e19", obs(), mdl);
        repeat (21) @(negedge clk);
        chk("hold_norepeat", obs(), mdl);
        set_btn(5'b0);
        repeat (25) @(negedge clk);

        set_btn(RT);
        repeat (10) @(negedge clk);
        set_btn(5'b0);
        repeat (25) @(negedge clk);
        chk("glitch10", obs(), mdl);

        press("left_to0", LT);
        press("left_wrap", LT);
        press("up_wrap", UP);
        press("right_wrap", RT);
        press("r1", RT);
        press("r2", RT);
        press("u1", UP);
        press("u2", UP);
        press("place_25", PL);
        press("right_35", RT);
        press("place_35", PL);
        press("remove_35", PL);
        press("right_45", RT);
        press("up_44", UP);
        press("place_up_same", PL | UP);

        bus.game_active = 1'b0;
        repeat (2) @(negedge clk);
        set_btn(RT);
        repeat (30) @(negedge clk);
        chk("lock_press", obs(), mdl);
        bus.game_active = 1'b1;
        repeat (30) @(negedge clk);
        chk("unlock_held", obs(), mdl);
        set_btn(5'b0);
        repeat (25) @(negedge clk);
        press("unlock_repress", RT);

        press("r_64", RT);
        press("u_63", UP);
        press("u_62", UP);
        bus.new_game = 1'b1;
        @(negedge clk);
        bus.new_game = 1'b0;
        mdl = '0;
        chk("new_game", obs(), mdl);

        press("ng_right", RT);
        press("ng_place", PL);
        set_btn(RT);
        repeat (8) @(negedge clk);
        nrst = 1'b0;
        #1;
        mdl = '0;
        chk("rst_mid", obs(), mdl);
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        mdl = apply(mdl, RT);
        exp_q.push_back(mdl);
        await_act("rst_reheld");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
